// File: rtl/dhs_axil2apb_bridge.sv
// AXI4-Lite slave to APB master bridge: one transaction in flight, round-robin
// read/write arbitration, SETUP/ACCESS sequencing and a PREADY timeout.
module dhs_axil2apb_bridge #(
  parameter int unsigned TimeoutCycles = 1023
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  // AXI4-Lite write address / data / response
  input  logic [31:0] awaddr,
  input  logic [2:0]  awprot,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wvalid,
  output logic        wready,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready,
  // AXI4-Lite read address / data
  input  logic [31:0] araddr,
  input  logic [2:0]  arprot,
  input  logic        arvalid,
  output logic        arready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rvalid,
  input  logic        rready,
  // APB master
  output logic [31:0] paddr,
  output logic [2:0]  pprot,
  output logic        psel,
  output logic        penable,
  output logic        pwrite,
  output logic [31:0] pwdata,
  output logic [3:0]  pstrb,
  input  logic        pready,
  input  logic [31:0] prdata,
  input  logic        pslverr
);

  localparam int unsigned CntW = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
  localparam bit TimeoutEn = (TimeoutCycles > 0);
  localparam logic [CntW-1:0] TimeoutVal = CntW'(TimeoutCycles);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } state_t;

  state_t state_reg, state_next;

  logic [CntW-1:0] cnt_reg, cnt_next;
  logic            last_wr_reg;
  logic            is_wr_reg;
  logic [31:0]     addr_reg;
  logic [2:0]      prot_reg;
  logic [31:0]     wdata_reg;
  logic [3:0]      strb_reg;
  logic            psel_reg, penable_reg;
  logic            bvalid_reg, rvalid_reg;
  logic [1:0]      bresp_reg, rresp_reg;
  logic [31:0]     rdata_reg;

  logic wr_elig, rd_elig;
  logic grant_wr, grant_rd;
  logic done, abort;

  assign wr_elig = awvalid && wvalid;
  assign rd_elig = arvalid;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    grant_wr   = 1'b0;
    grant_rd   = 1'b0;
    done       = 1'b0;
    abort      = 1'b0;
    unique case (state_reg)
      IDLE: begin
        // On a tie the type that was not served last wins.
        if (wr_elig && rd_elig) begin
          grant_wr = !last_wr_reg;
          grant_rd = last_wr_reg;
        end else begin
          grant_wr = wr_elig;
          grant_rd = rd_elig;
        end
        if (wr_elig || rd_elig) begin
          state_next = SETUP;
        end
      end
      SETUP: begin
        cnt_next   = '0;
        state_next = ACCESS;
      end
      ACCESS: begin
        if (pready) begin
          done       = 1'b1;
          state_next = RESP;
        end else begin
          cnt_next = cnt_reg + CntW'(1);
          // cnt_next counts completed wait cycles, so this fires in ACCESS cycle TimeoutCycles.
          if (TimeoutEn && (cnt_next == TimeoutVal)) begin
            abort      = 1'b1;
            state_next = RESP;
          end
        end
      end
      RESP: begin
        if (is_wr_reg ? bready : rready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      last_wr_reg <= 1'b0;
      is_wr_reg   <= 1'b0;
      addr_reg    <= '0;
      prot_reg    <= '0;
      wdata_reg   <= '0;
      strb_reg    <= '0;
      psel_reg    <= 1'b0;
      penable_reg <= 1'b0;
      bvalid_reg  <= 1'b0;
      bresp_reg   <= 2'b00;
      rvalid_reg  <= 1'b0;
      rresp_reg   <= 2'b00;
      rdata_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;

      if (grant_wr) begin
        addr_reg    <= awaddr;
        prot_reg    <= awprot;
        wdata_reg   <= wdata;
        strb_reg    <= wstrb;
        is_wr_reg   <= 1'b1;
        last_wr_reg <= 1'b1;
      end else if (grant_rd) begin
        addr_reg    <= araddr;
        prot_reg    <= arprot;
        strb_reg    <= 4'h0;
        is_wr_reg   <= 1'b0;
        last_wr_reg <= 1'b0;
      end

      psel_reg    <= (state_next == SETUP) || (state_next == ACCESS);
      penable_reg <= (state_next == ACCESS);

      if ((done || abort) && is_wr_reg) begin
        bvalid_reg <= 1'b1;
        bresp_reg  <= (abort || pslverr) ? 2'b10 : 2'b00;
      end else if (bvalid_reg && bready) begin
        bvalid_reg <= 1'b0;
      end

      if ((done || abort) && !is_wr_reg) begin
        rvalid_reg <= 1'b1;
        rresp_reg  <= (abort || pslverr) ? 2'b10 : 2'b00;
        rdata_reg  <= abort ? 32'h0 : prdata;
      end else if (rvalid_reg && rready) begin
        rvalid_reg <= 1'b0;
      end
    end
  end

  // Readies are gated by reset so nothing is accepted while reset is asserted.
  assign awready = grant_wr && rst_ni;
  assign wready  = grant_wr && rst_ni;
  assign arready = grant_rd && rst_ni;

  assign paddr   = addr_reg;
  assign pprot   = prot_reg;
  assign psel    = psel_reg;
  assign penable = penable_reg;
  assign pwrite  = is_wr_reg;
  assign pwdata  = wdata_reg;
  assign pstrb   = strb_reg;

  assign bvalid  = bvalid_reg;
  assign bresp   = bresp_reg;
  assign rvalid  = rvalid_reg;
  assign rresp   = rresp_reg;
  assign rdata   = rdata_reg;

endmodule

// File: doc/dhs_axil2apb_bridge.md
# dhs_axil2apb_bridge

Single-outstanding AXI4-Lite slave to APB (v2/APB3-style) master bridge on the peripheral side of the SoC: it takes a `dhs_axil` request stream produced downstream of the peripheral link crossbar and drives one `dhs_apb` bus serving the 4 KiB CSR windows. Those windows are SOC_CTRL 0x2000_0000, UART 0x2000_1000, SPI_CSR 0x2000_2000, PLIC 0x2000_3000, CLINT 0x2000_4000 and DMA 0x2000_5000. Reads and writes are arbitrated round-robin, serialized through a SETUP/ACCESS sequencer, and guarded by a PREADY timeout that converts hung slaves into SLVERR.

## Interface
- `TimeoutCycles`, default 1023: maximum ACCESS cycles before abort; 0 disables the timeout.
- `clk_i` input, 1 bit: clock, all logic on the rising edge.
- `rst_ni` input, 1 bit: synchronous, active-low reset.
- `axil_req_i` input, `dhs_axil_req_t`: AW/W/AR channels plus bready/rready (32-bit addr, 32-bit data, 4-bit strb).
- `axil_resp_o` output, `dhs_axil_resp_t`: aw/w/ar ready, B and R channels.
- `apb_req_o` output, `dhs_apb_req_t`: paddr, pprot, psel, penable, pwrite, pwdata, pstrb.
- `apb_resp_i` input, `dhs_apb_resp_t`: pready, prdata, pslverr.

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE. A write is eligible when awvalid && wvalid; a read is eligible when arvalid.
  - One eligible request: grant it.
  - Both eligible: grant the opposite of the last granted type. After reset the last type is read, so the first tie grants the write.
  - Grant write: awready = wready = 1 in that cycle, latching aw.addr, aw.prot, w.data and w.strb. Grant read: arready = 1, latching ar.addr and ar.prot.
  - Either grant moves the FSM to SETUP. AW is never accepted without W, nor W without AW.
- SETUP: psel=1, penable=0, paddr/pwrite/pwdata/pstrb/pprot from the latched values. The next state is always ACCESS.
- ACCESS: psel=1, penable=1, with the same address/control held.
  - pready=1: capture prdata (read) and pslverr, then go to RESP.
  - Timeout counter reaches TimeoutCycles with pready still 0: abort, record SLVERR, go to RESP.
- RESP, write: bvalid=1, bresp = 2'b10 on pslverr or timeout, else 2'b00.
- RESP, read: rvalid=1, rdata = captured prdata (0 on timeout), rresp uses the same rule as bresp.
- RESP exit: hold the response until bready or rready, then go to IDLE.
- pstrb is forced to 0 on reads. pwdata is don't-care on reads but driven with the latched value.
- No address decode. paddr is passed through unchanged, and unmapped handling belongs to the APB slave mux.
- Timeout counter:
  - Width $clog2(TimeoutCycles+1).
  - Cleared on SETUP and incremented each ACCESS cycle with pready=0.
  - Abort happens when count == TimeoutCycles, after exactly TimeoutCycles ACCESS cycles.
- Reset, all outputs 0: psel, penable, pwrite, paddr, pwdata, pstrb, pprot, every ready, bvalid, rvalid, bresp, rresp, rdata. FSM goes to IDLE; the last-granted flag goes to read.
- Reset mid-operation: the transaction is dropped with no B/R response. psel and penable fall to 0 in the cycle after reset is sampled low.

## Timing
- Ready signals are combinational from the valids in IDLE only, and 0 in all other states.
- Minimum write latency with an immediate slave (pready=1 in the first ACCESS cycle), request valid in cycle 0:
  - cycle 0: accept;
  - cycle 1: SETUP;
  - cycle 2: ACCESS, pready sampled;
  - cycle 3: bvalid=1.
- With bready=1 in cycle 3, the next request can be accepted in cycle 4. Peak throughput is one transfer per 4 cycles.
- Each cycle of pready=0 in ACCESS adds one cycle of latency.
- APB outputs are registered and stable from SETUP through the last ACCESS cycle. psel deasserts in the cycle after pready is sampled high.
- B/R outputs are registered. bresp/rresp/rdata are stable while valid is high and before the handshake.
- No new AXI request is accepted while in SETUP, ACCESS or RESP. At most one transaction is outstanding.

## Test plan
- Single write, pready immediate:
  - Stimulus: addr 0x2000_1004, data 0xDEAD_BEEF, strb 0xF.
  - Required: APB write seen with psel in cycles 1–2 and penable in cycle 2; bvalid in cycle 3 with bresp 2'b00.
- Single read with 3 wait states:
  - Stimulus: addr 0x2000_4000, slave returns 0x1234_5678.
  - Required: rvalid 3 cycles later than the minimum, rdata 0x1234_5678, rresp 00, pstrb 0.
- Simultaneous write and read valid, repeated 4 times, immediate slave:
  - Required grant order W, R, W, R.
  - Required: no AW accepted without W; paddr correct per transaction.
- Slave error: pslverr=1 with pready on a read of 0x2000_5010 -> rresp 2'b10, rdata = prdata.
- Timeout, TimeoutCycles=8, pready held 0:
  - Required: ACCESS lasts exactly 8 cycles, then psel falls.
  - Required: bresp 2'b10; a subsequent transaction completes normally.
- Backpressure and reset:
  - bready held 0 for 5 cycles -> bvalid and bresp stable and no new accept.
  - Then rst_ni low during ACCESS -> all outputs 0 in the next cycle and no B emitted after release.
